// File: rtl/timer_pkg.sv
// Shared definitions for the timer peripheral: run/idle encoding and divisor constants.
// Bus addresses for this block live in defines.vh (PERI_ADDR_TIMER_READ/WRITE).
package timer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [31:0] TIMER_DEFAULT_DIV = 32'd25000;
    localparam logic [31:0] TIMER_DIV_STOP    = 32'd0;

    // A zero divisor means the timer starts out stopped.
    function automatic state_t reset_state(input logic [31:0] div);
        return (div == TIMER_DIV_STOP) ? ST_IDLE : ST_RUN;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescale counter: divides clk by div and emits a one-cycle tick on the last count.
// restart clears the counter; when run is low the counter holds.
module timer_prescaler
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] div,
    input  logic        run,
    input  logic        restart,
    output logic        tick
);

    logic [31:0] r_pre;
    logic        w_last;

    assign w_last = (r_pre == (div - 32'd1));
    assign tick   = run & w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
        end else if (restart) begin
            r_pre <= '0;
        end else if (run) begin
            r_pre <= w_last ? 32'd0 : (r_pre + 32'd1);
        end
    end

endmodule

// File: rtl/timer_peri.sv
// Memory-mapped free-running tick counter; a write sets the divisor and restarts counting.
// Optional wrap interrupt output irq is built only when TIMER_IRQ_EN is defined.
module timer_peri
    import timer_pkg::*;
#(
    parameter int          CNT_W       = 32,
    parameter logic [31:0] DEFAULT_DIV = TIMER_DEFAULT_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
`ifdef TIMER_IRQ_EN
    ,
    output logic        irq
`endif
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_div;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_run;
    logic               w_restart;
    logic               w_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= reset_state(DEFAULT_DIV);
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (we) begin
            w_state_nxt = (wdata == TIMER_DIV_STOP) ? ST_IDLE : ST_RUN;
        end
    end

    // A write in any form takes priority over a tick on the same edge.
    always_comb begin
        w_run     = (r_state == ST_RUN) && !we;
        w_restart = we && (wdata != TIMER_DIV_STOP);
    end

    timer_prescaler u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .div     (r_div),
        .run     (w_run),
        .restart (w_restart),
        .tick    (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= DEFAULT_DIV;
        end else if (w_restart) begin
            r_div <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_restart) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign rdata = 32'(r_cnt);

`ifdef TIMER_IRQ_EN
    logic r_irq;

    // Tick already excludes write cycles, so a write on the wrap edge suppresses the pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_tick & (&r_cnt);
        end
    end

    assign irq = r_irq;
`endif

endmodule

// File: tb/tb_timer_peri.sv
// Scoreboard bench for timer_peri: a 32-bit default instance (A) and a 4-bit instance
// that resets stopped (B). Wrap interrupt checks are included when TIMER_IRQ_EN is defined.
module tb_timer_peri;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we_a = 1'b0;
    logic [31:0] wd_a = '0;
    logic [31:0] rd_a;
    logic        we_b = 1'b0;
    logic [31:0] wd_b = '0;
    logic [31:0] rd_b;
`ifdef TIMER_IRQ_EN
    logic        irq_a;
    logic        irq_b;
`endif

    always #5 clk = ~clk;

    timer_peri #(.CNT_W(32), .DEFAULT_DIV(32'd25000)) u_dut_a (
        .clk   (clk),
        .rst   (rst),
        .we    (we_a),
        .wdata (wd_a),
        .rdata (rd_a)
`ifdef TIMER_IRQ_EN
        ,
        .irq   (irq_a)
`endif
    );

    timer_peri #(.CNT_W(4), .DEFAULT_DIV(32'd0)) u_dut_b (
        .clk   (clk),
        .rst   (rst),
        .we    (we_b),
        .wdata (wd_b),
        .rdata (rd_b)
`ifdef TIMER_IRQ_EN
        ,
        .irq   (irq_b)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // kind: 0 = rdata A, 1 = rdata B, 2 = irq B
    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] exp;
    } sb_t;
    sb_t   sb_q[$];
    string ph = "init";

    always begin
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            sb_t e;
            e = sb_q.pop_front();
            case (e.kind)
                0: chk(e.tag, rd_a, e.exp);
                1: chk(e.tag, rd_b, e.exp);
`ifdef TIMER_IRQ_EN
                2: chk(e.tag, {31'd0, irq_b}, e.exp);
`endif
                default: ;
            endcase
        end
    end

    // Reference counts: while running, count = edges since restart / divisor.
    bit          a_run, b_run, b_irq;
    int unsigned a_div, a_k, a_frz;
    int unsigned b_div, b_k, b_frz;

    function automatic int unsigned a_cnt();
        return a_run ? (a_k / a_div) : a_frz;
    endfunction

    function automatic int unsigned b_cnt();
        return b_run ? ((b_k / b_div) % 16) : b_frz;
    endfunction

    task automatic model_reset();
        a_run = 1'b1; a_div = 25000; a_k = 0; a_frz = 0;
        b_run = 1'b0; b_div = 1;     b_k = 0; b_frz = 0; b_irq = 1'b0;
    endtask

    // Called at a negedge: drive inputs, record what the next posedge must produce.
    task automatic step(input logic wa, input logic [31:0] da,
                        input logic wb, input logic [31:0] db);
        sb_t e;
        we_a = wa; wd_a = da; we_b = wb; wd_b = db;
        if (wa) begin
            if (da == 0) begin
                if (a_run) a_frz = a_cnt();
                a_run = 1'b0;
            end else begin
                a_div = da; a_k = 0; a_run = 1'b1;
            end
        end else if (a_run) begin
            a_k++;
        end
        b_irq = 1'b0;
        if (wb) begin
            if (db == 0) begin
                if (b_run) b_frz = b_cnt();
                b_run = 1'b0;
            end else begin
                b_div = db; b_k = 0; b_run = 1'b1;
            end
        end else if (b_run) begin
            b_k++;
            if ((b_k % b_div == 0) && ((b_k / b_div) % 16 == 0)) b_irq = 1'b1;
        end
        e.tag = {ph, "/rdA"}; e.kind = 0; e.exp = a_cnt(); sb_q.push_back(e);
        e.tag = {ph, "/rdB"}; e.kind = 1; e.exp = b_cnt(); sb_q.push_back(e);
`ifdef TIMER_IRQ_EN
        e.tag = {ph, "/irqB"}; e.kind = 2; e.exp = {31'd0, b_irq}; sb_q.push_back(e);
`endif
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic wr_a(input logic [31:0] d);
        step(1'b1, d, 1'b0, 32'd0);
    endtask

    task automatic wr_b(input logic [31:0] d);
        step(1'b0, 32'd0, 1'b1, d);
    endtask

    initial begin
        // Asynchronous reset before any clock edge; writes during reset are ignored.
        #2 rst = 1'b1;
        #1;
        chk("por_async/rdA", rd_a, 32'd0);
        chk("por_async/rdB", rd_b, 32'd0);
`ifdef TIMER_IRQ_EN
        chk("por_async/irqB", {31'd0, irq_b}, 32'd0);
        chk("por_async/irqA", {31'd0, irq_a}, 32'd0);
`endif
        we_a = 1'b1; wd_a = 32'd7;
        we_b = 1'b1; wd_b = 32'd1;
        repeat (3) @(negedge clk);
        rst = 1'b0; we_a = 1'b0; wd_a = '0; we_b = 1'b0; wd_b = '0;
        model_reset();

        ph = "default_div";
        idle(25000);

        ph = "div4";
        wr_a(32'd4);
        idle(12);

        ph = "freeze";
        wr_a(32'd1);
        idle(11);
        wr_a(32'd0);
        idle(50);
        wr_a(32'd1);
        idle(6);

        ph = "write_on_tick";
        wr_a(32'd3);
        idle(17);
        wr_a(32'd3);
        idle(4);

        ph = "b_wrap";
        wr_b(32'd1);
        idle(15);
        wr_b(32'd1);
        idle(40);
        wr_b(32'd0);
        idle(5);
        wr_b(32'd2);
        idle(34);

        ph = "rst_mid";
        wr_a(32'd2);
        wr_b(32'd1);
        idle(13);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_async/rdA", rd_a, 32'd0);
        chk("rst_mid_async/rdB", rd_b, 32'd0);
        rst = 1'b0;
        model_reset();
        ph = "after_rst";
        idle(30);

        @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
